// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// The master side produces operands and consumes results. The slave side is the pipe itself.
interface logic_unit_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             flag_zero;
   logic             flag_ones;
   logic             flag_parity;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, flag_zero, flag_ones, flag_parity
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, flag_zero, flag_ones, flag_parity
   );
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with result flags.
// Results pass through a 2-entry skid buffer, so in_ready is a register output.
module logic_unit_pipe #(
   parameter int WIDTH = 8
) (
   input logic              clk,
   input logic              rst_n,
   logic_unit_pipe_if.slave bus
);
   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic             zero;
      logic             ones;
      logic             parity;
   } entry_t;

   localparam entry_t RESET_ENTRY = '{result: '0, zero: 1'b1, ones: 1'b0, parity: 1'b0};

   entry_t           new_entry;
   logic [WIDTH-1:0] op_res;

   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   logic   main_v_q, main_v_d;
   logic   skid_v_q, skid_v_d;
   logic   in_ready_q;

   logic accept;
   logic main_free;

   // The op is applied once, at accept time. Only the finished result and flags are stored.
   always_comb begin
      // NOTE: assign a default before the case so that no path leaves op_res unassigned, which would infer a latch.
      op_res = '0;
      unique case (bus.op)
         3'd0: op_res = bus.a & bus.b;
         3'd1: op_res = bus.a | bus.b;
         3'd2: op_res = bus.a ^ bus.b;
         3'd3: op_res = ~(bus.a & bus.b);
         3'd4: op_res = ~(bus.a | bus.b);
         3'd5: op_res = ~(bus.a ^ bus.b);
         3'd6: op_res = bus.a & ~bus.b;
         3'd7: op_res = bus.a;
         default: op_res = '0;
      endcase
      new_entry = '{result: op_res, zero: ~|op_res, ones: &op_res, parity: ^op_res};
   end

   assign accept    = bus.in_valid & in_ready_q;
   assign main_free = ~main_v_q | bus.out_ready;

   always_comb begin
      main_d   = main_q;
      main_v_d = main_v_q;
      skid_d   = skid_q;
      skid_v_d = skid_v_q;
      if (main_free) begin
         if (skid_v_q) begin
            // The queued entry moves up to main. A new arrival takes its place, which keeps the order FIFO.
            main_d   = skid_q;
            main_v_d = 1'b1;
            if (accept) begin
               skid_d = new_entry;
            end else begin
               skid_v_d = 1'b0;
            end
         end else if (accept) begin
            main_d   = new_entry;
            main_v_d = 1'b1;
         end else begin
            main_v_d = 1'b0;
         end
      end else if (accept) begin
         skid_d   = new_entry;
         skid_v_d = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments, so every flop samples the values from before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q     <= RESET_ENTRY;
         main_v_q   <= 1'b0;
         skid_q     <= RESET_ENTRY;
         skid_v_q   <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         main_q     <= main_d;
         main_v_q   <= main_v_d;
         skid_q     <= skid_d;
         skid_v_q   <= skid_v_d;
         in_ready_q <= ~skid_v_d;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = main_v_q;
   assign bus.result      = main_q.result;
   assign bus.flag_zero   = main_q.zero;
   assign bus.flag_ones   = main_q.ones;
   assign bus.flag_parity = main_q.parity;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe. It covers directed handshake cases, random traffic and a WIDTH=1 build.
module tb_logic_unit_pipe;
  localparam int W = 8;
  typedef logic [W+2:0] exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(W)) bus8 ();
  logic_unit_pipe_if #(.WIDTH(1)) bus1 ();

  logic_unit_pipe #(.WIDTH(W)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  logic_unit_pipe #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Each op is described by its 2-input truth table, indexed by {a_bit, b_bit}.
  function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    logic [3:0]   tt;
    logic [W-1:0] r;
    int           ones;
    case (op)
      3'd0: tt = 4'b1000;
      3'd1: tt = 4'b1110;
      3'd2: tt = 4'b0110;
      3'd3: tt = 4'b0111;
      3'd4: tt = 4'b0001;
      3'd5: tt = 4'b1001;
      3'd6: tt = 4'b0100;
      default: tt = 4'b1100;
    endcase
    ones = 0;
    for (int i = 0; i < W; i++) begin
      r[i] = tt[{a[i], b[i]}];
      if (r[i]) ones++;
    end
    return {r, ones == 0, ones == W, (ones % 2) == 1};
  endfunction

  // Monitor: pop and compare on every output transfer, and push the expected entry on every accept.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bus8.out_valid && bus8.out_ready) begin
          if (sb_q.size() == 0) begin
            check("sb_unexpected_output", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("sb_entry",
                  32'({bus8.result, bus8.flag_zero, bus8.flag_ones, bus8.flag_parity}), 32'(e));
          end
        end
        if (bus8.in_valid && bus8.in_ready)
          sb_q.push_back(ref_model(bus8.a, bus8.b, bus8.op));
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    int n;
    n = 0;
    bus8.a = a;
    bus8.b = b;
    bus8.op = op;
    bus8.in_valid = 1'b1;
    @(negedge clk);
    while (!bus8.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus8.in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] tv_exp [8];
  logic       and_exp [4];
  int         n;

  initial begin
    tv_exp = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h30, 8'hF0};
    and_exp = '{1'b0, 1'b0, 1'b0, 1'b1};
    rst_n = 1'b0;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.op = '0; bus8.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.op = '0; bus1.out_ready = 1'b0;

    #7;
    check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
    check("rst_result", 32'(bus8.result), 32'd0);
    check("rst_zero", 32'(bus8.flag_zero), 32'd1);
    check("rst_ones", 32'(bus8.flag_ones), 32'd0);
    check("rst_parity", 32'(bus8.flag_parity), 32'd0);
    #5 rst_n = 1'b1;
    tick();

    // Truth sweep: one result per cycle, each visible one cycle after its accept.
    bus8.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(8'hF0, 8'hCC, 3'(i));
      check("sweep_result", 32'(bus8.result), 32'(tv_exp[i]));
      check("sweep_valid", 32'(bus8.out_valid), 32'd1);
    end
    bus8.in_valid = 1'b0;
    tick();
    check("sweep_drained", 32'(bus8.out_valid), 32'd0);

    send(8'hFF, 8'hFF, 3'd2);
    check("flag_zero_set", 32'({bus8.result, bus8.flag_zero, bus8.flag_ones, bus8.flag_parity}), 32'({8'h00, 3'b100}));
    send(8'hFF, 8'h00, 3'd7);
    check("flag_ones_set", 32'({bus8.flag_zero, bus8.flag_ones, bus8.flag_parity}), 32'(3'b010));
    send(8'h01, 8'h00, 3'd7);
    check("flag_parity_set", 32'({bus8.flag_zero, bus8.flag_ones, bus8.flag_parity}), 32'(3'b001));
    bus8.in_valid = 1'b0;
    tick();

    // Backpressure: the third entry waits until the skid drains.
    bus8.out_ready = 1'b0;
    send(8'hAA, 8'h0F, 3'd0);
    check("bp_ready_after_first", 32'(bus8.in_ready), 32'd1);
    send(8'h55, 8'hF0, 3'd1);
    check("bp_ready_after_second", 32'(bus8.in_ready), 32'd0);
    bus8.a = 8'h12; bus8.b = 8'h34; bus8.op = 3'd2; bus8.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ready_held_low", 32'(bus8.in_ready), 32'd0);
      check("bp_result_stable", 32'(bus8.result), 32'h0A);
    end
    bus8.out_ready = 1'b1;
    tick();
    check("bp_second_out", 32'(bus8.result), 32'hF5);
    check("bp_second_valid", 32'(bus8.out_valid), 32'd1);
    tick();
    check("bp_third_out", 32'(bus8.result), 32'h26);
    check("bp_third_valid", 32'(bus8.out_valid), 32'd1);
    bus8.in_valid = 1'b0;
    tick();

    // Accept and transfer on the same edge while only main is full.
    send(8'h3C, 8'h0F, 3'd2);
    check("simul_first", 32'(bus8.result), 32'h33);
    send(8'hC3, 8'hF0, 3'd6);
    check("simul_second", 32'(bus8.result), 32'h03);
    check("simul_in_ready", 32'(bus8.in_ready), 32'd1);
    bus8.in_valid = 1'b0;
    tick();

    // Reset with both entries full.
    bus8.out_ready = 1'b0;
    send(8'h11, 8'h22, 3'd1);
    send(8'h44, 8'h88, 3'd1);
    bus8.in_valid = 1'b0;
    check("mid_full_ready", 32'(bus8.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus8.out_valid), 32'd0);
    check("mid_rst_ready", 32'(bus8.in_ready), 32'd1);
    check("mid_rst_result", 32'(bus8.result), 32'd0);
    check("mid_rst_zero", 32'(bus8.flag_zero), 32'd1);
    sb_q.delete();
    #2 rst_n = 1'b1;
    tick();
    bus8.out_ready = 1'b1;
    send(8'h0F, 8'hF0, 3'd1);
    check("post_rst_result", 32'(bus8.result), 32'hFF);
    check("post_rst_ones", 32'(bus8.flag_ones), 32'd1);
    bus8.in_valid = 1'b0;
    tick();

    // Random traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      bus8.in_valid  = ($urandom_range(0, 3) != 0);
      bus8.out_ready = ($urandom_range(0, 9) < 6);
      bus8.a  = W'($urandom);
      bus8.b  = W'($urandom);
      bus8.op = 3'($urandom);
      tick();
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    n = 0;
    while ((sb_q.size() != 0 || bus8.out_valid) && n < 20) begin
      n++;
      tick();
    end
    check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
    check("drain_out_valid", 32'(bus8.out_valid), 32'd0);

    // WIDTH=1 build behaves as the original 2-input gate.
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus1.a = 1'((i >> 1) & 1);
      bus1.b = 1'(i & 1);
      bus1.op = 3'd0;
      bus1.in_valid = 1'b1;
      tick();
      check("w1_and_result", 32'(bus1.result), 32'(and_exp[i]));
      check("w1_flag_ones", 32'(bus1.flag_ones), 32'(and_exp[i]));
      check("w1_flag_parity", 32'(bus1.flag_parity), 32'(and_exp[i]));
    end
    bus1.in_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
